// File: rtl/rgb2ycbcr_lanes_if.sv
// rgb2ycbcr_lanes_if: pixel stream interface for rgb2ycbcr_lanes.
// Carries the RGB input beat (data, valid/ready, studio-range select, frame end)
// and the YCbCr output beat (Y/Cb/Cr lanes, valid/ready, frame end).
// The converter attaches through the slave modport; the stream source/sink uses master.
interface rgb2ycbcr_lanes_if #(
    parameter int LANES = 8,
    parameter int PIX_W = 8
);
    logic [LANES*3*PIX_W-1:0] i_data;
    logic                     i_valid;
    logic                     i_ready;
    logic                     i_studio;
    logic                     i_last;
    logic [LANES*PIX_W-1:0]   o_y;
    logic [LANES*PIX_W-1:0]   o_cb;
    logic [LANES*PIX_W-1:0]   o_cr;
    logic                     o_valid;
    logic                     o_ready;
    logic                     o_last;

    modport slave (
        input  i_data, i_valid, i_studio, i_last, o_ready,
        output i_ready, o_y, o_cb, o_cr, o_valid, o_last
    );

    modport master (
        output i_data, i_valid, i_studio, i_last, o_ready,
        input  i_ready, o_y, o_cb, o_cr, o_valid, o_last
    );
endinterface

// File: rtl/rgb2ycbcr_lanes.sv
// rgb2ycbcr_lanes: LANES-wide RGB -> YCbCr converter, 3-stage pipeline with
// valid/ready back-pressure. Stage 1 registers the 9 products per lane,
// stage 2 the three sums, stage 3 shift/offset/clamp into the output registers.
// Optional macro RGB2YCBCR_ROUND_EN: add 128 before the >>8 (round half up);
// undefined gives floor truncation.
module rgb2ycbcr_lanes #(
    parameter int LANES = 8,
    parameter int PIX_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rgb2ycbcr_lanes_if.slave   bus
);
    localparam int AW = PIX_W + 10;
    localparam int S  = PIX_W - 8;

    typedef logic signed [AW-1:0] acc_t;

    localparam acc_t ONE   = acc_t'(1'b1);
    localparam acc_t C_OFF = ONE << (PIX_W - 1);
    localparam acc_t Y_OFF = acc_t'(5'd16) << S;
    localparam acc_t MAXV  = (ONE << PIX_W) - ONE;
`ifdef RGB2YCBCR_ROUND_EN
    localparam acc_t RND   = acc_t'(8'd128);
`else
    localparam acc_t RND   = acc_t'(8'd0);
`endif

    // Coefficient table: idx 0..2 = Y(R,G,B), 3..5 = Cb(R,G,B), 6..8 = Cr(R,G,B).
    function automatic logic signed [9:0] coef(input logic studio, input logic [3:0] idx);
        logic signed [9:0] c;
        if (!studio) begin
            case (idx)
                4'd0:    c = 10'sd77;
                4'd1:    c = 10'sd150;
                4'd2:    c = 10'sd29;
                4'd3:    c = -10'sd43;
                4'd4:    c = -10'sd85;
                4'd5:    c = 10'sd128;
                4'd6:    c = 10'sd128;
                4'd7:    c = -10'sd107;
                4'd8:    c = -10'sd21;
                default: c = 10'sd0;
            endcase
        end else begin
            case (idx)
                4'd0:    c = 10'sd66;
                4'd1:    c = 10'sd129;
                4'd2:    c = 10'sd25;
                4'd3:    c = -10'sd38;
                4'd4:    c = -10'sd74;
                4'd5:    c = 10'sd112;
                4'd6:    c = 10'sd112;
                4'd7:    c = -10'sd94;
                4'd8:    c = -10'sd18;
                default: c = 10'sd0;
            endcase
        end
        return c;
    endfunction

    // Component extraction: comp 0 = R (upper), 1 = G, 2 = B (lower).
    function automatic logic [PIX_W-1:0] pix(input logic [LANES*3*PIX_W-1:0] d,
                                             input int lane, input int comp);
        return d[lane*3*PIX_W + (2-comp)*PIX_W +: PIX_W];
    endfunction

    // Signed coefficient times unsigned pixel, both widened to the accumulator.
    function automatic acc_t mul(input logic signed [9:0] c, input logic [PIX_W-1:0] p);
        acc_t ce;
        acc_t pe;
        ce = {{(AW-10){c[9]}}, c};
        pe = {{(AW-PIX_W){1'b0}}, p};
        return ce * pe;
    endfunction

    // Rounding (build option), floor shift, offset and clamp to [0, 2^PIX_W-1].
    function automatic logic [PIX_W-1:0] finish(input acc_t sum, input acc_t off);
        acc_t res;
        res = ((sum + RND) >>> 8) + off;
        if (res[AW-1]) begin
            return {PIX_W{1'b0}};
        end else if (res > MAXV) begin
            return {PIX_W{1'b1}};
        end else begin
            return res[PIX_W-1:0];
        end
    endfunction

    logic en1_s, en2_s, en3_s;
    logic v1_q, v2_q, v3_q;
    logic st1_q, st2_q;
    logic last1_q, last2_q, last3_q;
    acc_t prod_d [LANES][9];
    acc_t prod_q [LANES][9];
    acc_t sum_d  [LANES][3];
    acc_t sum_q  [LANES][3];
    logic [LANES*PIX_W-1:0] y_d, cb_d, cr_d;
    logic [LANES*PIX_W-1:0] y_q, cb_q, cr_q;

    // Ready chain: a stage may load when it is empty or the next stage loads.
    assign en3_s = !v3_q || bus.o_ready;
    assign en2_s = !v2_q || en3_s;
    assign en1_s = !v1_q || en2_s;

    // Stage 1 next state: the 9 coefficient products of every lane.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < 9; j++) begin
                prod_d[k][j] = mul(coef(bus.i_studio, 4'(j)), pix(bus.i_data, k, j % 3));
            end
        end
    end

    // Stage 1 registers: products, mode and frame end of the accepted beat.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            v1_q    <= 1'b0;
            st1_q   <= 1'b0;
            last1_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                for (int j = 0; j < 9; j++) begin
                    prod_q[k][j] <= '0;
                end
            end
        end else begin
            if (en1_s) begin
                v1_q <= bus.i_valid;
            end
            if (en1_s && bus.i_valid) begin
                prod_q  <= prod_d;
                st1_q   <= bus.i_studio;
                last1_q <= bus.i_last;
            end
        end
    end

    // Stage 2 next state: Y, Cb and Cr sums per lane.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            for (int m = 0; m < 3; m++) begin
                sum_d[k][m] = prod_q[k][3*m] + prod_q[k][3*m+1] + prod_q[k][3*m+2];
            end
        end
    end

    // Stage 2 registers: sums plus the sideband of the beat.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            v2_q    <= 1'b0;
            st2_q   <= 1'b0;
            last2_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                for (int m = 0; m < 3; m++) begin
                    sum_q[k][m] <= '0;
                end
            end
        end else begin
            if (en2_s) begin
                v2_q <= v1_q;
            end
            if (en2_s && v1_q) begin
                sum_q   <= sum_d;
                st2_q   <= st1_q;
                last2_q <= last1_q;
            end
        end
    end

    // Stage 3 next state: final Y/Cb/Cr values; Y gets the studio black level.
    always_comb begin
        y_d  = '0;
        cb_d = '0;
        cr_d = '0;
        for (int k = 0; k < LANES; k++) begin
            y_d[k*PIX_W +: PIX_W]  = finish(sum_q[k][0], st2_q ? Y_OFF : '0);
            cb_d[k*PIX_W +: PIX_W] = finish(sum_q[k][1], C_OFF);
            cr_d[k*PIX_W +: PIX_W] = finish(sum_q[k][2], C_OFF);
        end
    end

    // Stage 3 registers drive the outputs directly; they hold while stalled.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            v3_q    <= 1'b0;
            last3_q <= 1'b0;
            y_q     <= '0;
            cb_q    <= '0;
            cr_q    <= '0;
        end else begin
            if (en3_s) begin
                v3_q <= v2_q;
            end
            if (en3_s && v2_q) begin
                y_q     <= y_d;
                cb_q    <= cb_d;
                cr_q    <= cr_d;
                last3_q <= last2_q;
            end
        end
    end

    assign bus.i_ready = en1_s;
    assign bus.o_valid = v3_q;
    assign bus.o_last  = last3_q;
    assign bus.o_y     = y_q;
    assign bus.o_cb    = cb_q;
    assign bus.o_cr    = cr_q;
endmodule

// File: doc/rgb2ycbcr_lanes.md
# rgb2ycbcr_lanes

Parametrised multi-lane RGB→YCbCr colour-space converter for the preprocessing datapath. It takes LANES packed RGB pixels per beat and produces LANES Y/Cb/Cr triples through a 3-stage pipeline. The pipeline uses valid/ready handshaking with full back-pressure, a runtime full-range/studio-range select and a frame-end sideband. It replaces fixed 8-lane instances whose valid was derived from data, so downstream blocks (chroma subsampling, DCT feeders) get a true qualified stream.

## Interface
Parameters:
- LANES, 8, pixels per beat (≥1)
- PIX_W, 8, bits per colour component (≥8)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_data  in  LANES*3*PIX_W  lane k at [k*3*PIX_W +: 3*PIX_W]; within a lane R is the upper PIX_W bits, G the middle, B the lower
- i_valid  in  1  beat present
- i_ready  out  1  block accepts beat this cycle
- i_studio  in  1  per-beat mode: 0 = full range, 1 = studio range
- i_last  in  1  last beat of frame, carried through aligned with data
- o_y, o_cb, o_cr  out  LANES*PIX_W each  lane k at [k*PIX_W +: PIX_W]
- o_valid  out  1  output beat present
- o_ready  in  1  downstream accepts
- o_last  out  1  i_last of the beat on the outputs

## Operation
- Beat transfer on input when i_valid && i_ready; on output when o_valid && o_ready.
- Coefficients are 8 fractional bits, identical for all lanes. Define S = PIX_W-8, and use a signed accumulator of width PIX_W+10.
- Full range:
  - Y = (77R+150G+29B)>>8
  - Cb = ((-43R-85G+128B)>>8) + 2^(PIX_W-1)
  - Cr = ((128R-107G-21B)>>8) + 2^(PIX_W-1)
- Studio range:
  - Y = ((66R+129G+25B)>>8) + 16·2^S
  - Cb = ((-38R-74G+112B)>>8) + 2^(PIX_W-1)
  - Cr = ((112R-94G-18B)>>8) + 2^(PIX_W-1)
- >>8 is an arithmetic (floor) shift.
- Each result is clamped to [0, 2^PIX_W-1] after the offset is added.
- Stage 1 registers the 9 products per lane. Stage 2 registers the three sums. Stage 3 applies rounding, shift, offset and clamp, and drives the outputs.
- i_studio and i_last travel with their beat through all stages. Mode may change on any beat with no bubble.

## Timing
- Latency: 3 cycles from input transfer to o_valid with an unstalled pipeline. Throughput is 1 beat/cycle.
- Stage enables: en3 = !v3 || o_ready; en2 = !v2 || en3; en1 = !v1 || en2; i_ready = en1. A stage loads when its enable is high; its valid then takes the previous stage's valid (i_valid for stage 1).
- Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- The ready path is combinational through the three stages. The block holds 3 beats while o_ready is low, and i_ready drops only once all 3 stages are full.
- While o_valid && !o_ready, o_y/o_cb/o_cr/o_last are held stable.
- A beat presented with i_valid=0 is ignored. Its data may toggle freely.
- Reset (i_rst low, asynchronous):
  - all stage valids go to 0; o_valid = 0
  - o_y/o_cb/o_cr/o_last = 0
  - in-flight beats are discarded
  - i_ready = 1 during and after reset
- Reset deasserted mid-stream: the first accepted beat appears 3 cycles later. There are no phantom beats.

## Configuration
- RGB2YCBCR_ROUND_EN defined: 128 is added to each sum before >>8 (round half up).
- Undefined: plain floor truncation.
- Offsets and clamping are unchanged in both builds.

## Test plan
- Full range, LANES=8, PIX_W=8, all lanes white (255,255,255), o_ready=1 → after 3 cycles every lane Y=255, Cb=128, Cr=128, o_valid=1 for 1 cycle. Black (0,0,0) gives 0/128/128.
- Studio range: white → 235/128/128; black → 16/128/128. Alternate i_studio per beat → outputs alternate with no bubble.
- Pure red (255,0,0), full range. Without the macro: Y=76, Cb=85, Cr=255 (127+128). With RGB2YCBCR_ROUND_EN: Y=77, Cb=85, Cr=255 (clamped from 256).
- Stream 10 beats with i_last on beat 10, hold o_ready=0 for cycles 4-8:
  - i_ready falls after 3 beats are buffered
  - outputs are held stable during the stall
  - all 10 beats emerge in order with no loss or duplication
  - o_last is set only on beat 10
- Assert i_rst low with 3 beats in flight → o_valid=0 and outputs 0 immediately (asynchronous), i_ready=1. After release, one new beat → output exactly 3 cycles later.
- Per-lane distinct pixels (lane k = (32k, 255-32k, 16k)) → each lane matches the reference model independently, with no lane swap.
